// File: rtl/ntt_poly_loader.sv
// ntt_poly_loader
// Buffers one polynomial arriving as a serial word stream. It then replays
// that polynomial into an (I)NTT processor's start/data_in port in banked,
// two-lane order.
//
// Storage is 2*C banks of B words each. Word j is stored in lane
// h = j / (W/2), core k = (j mod W/2) / B, at address j mod B. In drain beat
// i, core k receives word k*B+i on lane 0 and word k*B+i+W/2 on lane 1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   loader can accept a word (from state and replay only)
//   in_data    input word, natural order 0..W-1
//   replay     single-cycle request to re-drain the buffered polynomial
//   start      processor start, high for B+1 cycles per pass
//   data_out   processor data_in. Entry [k][h] occupies
//              bits [(2*k+h)*DATA_W +: DATA_W]
//   beat_idx   index of the current drain beat (0 outside DRAIN)
//   buf_valid  buffer holds a complete polynomial
//   done       one-cycle pulse after a drain pass ends
module ntt_poly_loader #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 4,
    parameter int DATA_W         = 60
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic                                    replay,
    output logic                                    start,
    output logic [(2<<LOG_CORE_COUNT)*DATA_W-1:0]   data_out,
    output logic [LOG_N-3-LOG_CORE_COUNT:0]         beat_idx,
    output logic                                    buf_valid,
    output logic                                    done
);

    localparam int BEAT_W = LOG_N - 2 - LOG_CORE_COUNT;  // log2 of beats per pass
    localparam int CORES  = 1 << LOG_CORE_COUNT;
    localparam int BANKS  = 2 * CORES;
    localparam int BEATS  = 1 << BEAT_W;
    localparam int WORD_W = LOG_N - 1;                    // word index width

    localparam logic [WORD_W-1:0] LAST_WORD = '1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRIME,
        DRAIN
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  fill_cnt;

    logic               accept;
    logic [WORD_W-1:0]  wr_word;
    logic               wr_lane;
    logic [WORD_W-2:0]  wr_core;
    logic [BEAT_W-1:0]  wr_addr;
    logic               rd_en;
    logic [BEAT_W-1:0]  rd_addr;

    // in_ready deliberately ignores in_valid. This keeps the handshake free
    // of combinational loops with an upstream source that waits on ready.
    assign in_ready = (state == FILL) || ((state == IDLE) && !replay);
    assign accept   = in_valid && in_ready;

    // In IDLE the accepted word is always word 0 of a new polynomial.
    assign wr_word = (state == FILL) ? fill_cnt : '0;
    assign wr_lane = wr_word[WORD_W-1];
    assign wr_core = wr_word[WORD_W-2:0] >> BEAT_W;
    assign wr_addr = wr_word[BEAT_W-1:0];

    // PRIME issues address 0. Each DRAIN beat issues the next address, so
    // the data lands one cycle later on the following beat.
    assign rd_en   = (state == PRIME) || ((state == DRAIN) && (beat_idx != LAST_BEAT));
    assign rd_addr = (state == DRAIN) ? beat_idx + 1'b1 : '0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int K = b / 2;
        localparam int H = b % 2;

        logic              bank_we;
        logic [DATA_W-1:0] mem [BEATS];
        logic [DATA_W-1:0] rd_q;

        assign bank_we = accept && (wr_lane == 1'(H)) && (wr_core == (WORD_W-1)'(K));

        // NOTE: the storage array has no reset. Its contents are don't-care
        // after reset, and leaving it unreset lets it map onto RAM.
        always_ff @(posedge clk) begin
            if (bank_we) begin
                mem[wr_addr] <= in_data;
            end
        end

        // The synchronous read register doubles as the output register. It
        // is forced to zero whenever the next cycle is not a drain beat.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr];
            end else begin
                rd_q <= '0;
            end
        end

        assign data_out[b*DATA_W +: DATA_W] = rd_q;
    end

    // NOTE: all state and registered outputs use non-blocking assignments,
    // so every branch reads the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            start     <= 1'b0;
            done      <= 1'b0;
            buf_valid <= 1'b0;
            beat_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // replay wins over a simultaneous word. A replay with an
                    // empty buffer is ignored.
                    if (replay) begin
                        if (buf_valid) begin
                            state <= PRIME;
                            start <= 1'b1;
                        end
                    end else if (in_valid) begin
                        buf_valid <= 1'b0;
                        fill_cnt  <= WORD_W'(1);
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (fill_cnt == LAST_WORD) begin
                            fill_cnt <= '0;
                            state    <= PRIME;
                            start    <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                PRIME: begin
                    state    <= DRAIN;
                    beat_idx <= '0;
                end
                DRAIN: begin
                    if (beat_idx == LAST_BEAT) begin
                        beat_idx  <= '0;
                        start     <= 1'b0;
                        done      <= 1'b1;
                        buf_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_poly_loader.sv
// Testbench for ntt_poly_loader.
// The main instance uses the default configuration (W=2048, C=16, B=64). A
// timeline model of fill and replay passes is checked against it every cycle.
// A small instance (W=8, C=2, B=2) is checked against hand-written values.
module tb_ntt_poly_loader;

    localparam int LOG_N = 12;
    localparam int LCC   = 4;
    localparam int DW    = 60;
    localparam int W     = 1 << (LOG_N - 1);
    localparam int HALF  = W / 2;
    localparam int C     = 1 << LCC;
    localparam int BW    = LOG_N - 2 - LCC;
    localparam int B     = 1 << BW;
    localparam int OW    = 2 * C * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-configuration instance
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            replay = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic            start;
    logic [OW-1:0]   data_out;
    logic [BW-1:0]   beat_idx;
    logic            buf_valid;
    logic            done;

    ntt_poly_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .replay    (replay),
        .start     (start),
        .data_out  (data_out),
        .beat_idx  (beat_idx),
        .buf_valid (buf_valid),
        .done      (done)
    );

    // small-configuration instance
    logic        s_rst = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_replay = 1'b0;
    logic [7:0]  s_in_data = '0;
    logic        s_in_ready;
    logic        s_start;
    logic [31:0] s_data_out;
    logic [0:0]  s_beat_idx;
    logic        s_buf_valid;
    logic        s_done;

    ntt_poly_loader #(.LOG_N(4), .LOG_CORE_COUNT(1), .DATA_W(8)) dut_s (
        .clk       (clk),
        .rst       (s_rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .replay    (s_replay),
        .start     (s_start),
        .data_out  (s_data_out),
        .beat_idx  (s_beat_idx),
        .buf_valid (s_buf_valid),
        .done      (s_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One comparison per call; reports the first differing [k][h] entry.
    task automatic check_data(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int s = 0; s < 2 * C; s++) begin
                if (act[s*DW +: DW] !== exp[s*DW +: DW]) begin
                    $display("FAIL %s entry [%0d][%0d] got %0h expected %0h at %0t",
                             name, s / 2, s % 2, act[s*DW +: DW], exp[s*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] word_at(input int k, input int h);
        return data_out[(2*k+h)*DW +: DW];
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: the polynomial buffer, a fill count, and the
    // position m_p within a replay pass. Position 0 is the start-only cycle,
    // 1..B are the data beats and B+1 is the done cycle; -1 means no pass.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_buf [W];
    int            m_p = -1;
    int            m_cnt = 0;
    bit            m_bv = 1'b0;
    bit            m_in_pass;
    bit            m_ready;
    bit            m_accept;
    int            m_np;
    logic [OW-1:0] m_exp_d;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_start", 64'(start), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_buf_valid", 64'(buf_valid), 64'(0));
            check("rst_beat_idx", 64'(beat_idx), 64'(0));
            check_data("rst_data_out", data_out, '0);
            m_p   = -1;
            m_cnt = 0;
            m_bv  = 1'b0;
        end else begin
            m_in_pass = (m_p >= 0) && (m_p <= B);
            m_ready   = m_in_pass ? 1'b0 : ((m_cnt > 0) ? 1'b1 : !replay);
            m_exp_d   = '0;
            if (m_p >= 1 && m_p <= B) begin
                for (int k = 0; k < C; k++) begin
                    for (int h = 0; h < 2; h++) begin
                        m_exp_d[(2*k+h)*DW +: DW] = m_buf[k*B + (m_p-1) + h*HALF];
                    end
                end
            end
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("start", 64'(start), 64'(m_in_pass));
            check("done", 64'(done), 64'(m_p == B + 1));
            check("buf_valid", 64'(buf_valid), 64'(m_bv));
            check("beat_idx", 64'(beat_idx), (m_p >= 1 && m_p <= B) ? 64'(m_p - 1) : 64'(0));
            check_data("data_out", data_out, m_exp_d);

            // advance the model to the next cycle
            m_accept = in_valid && m_ready;
            m_np     = m_in_pass ? m_p + 1 : -1;
            if (m_p == B) m_bv = 1'b1;
            if (!m_in_pass) begin
                if (m_cnt == 0) begin
                    if (replay && m_bv) begin
                        m_np = 0;
                    end else if (m_accept) begin
                        m_buf[0] = in_data;
                        m_bv     = 1'b0;
                        m_cnt    = 1;
                    end
                end else if (m_accept) begin
                    m_buf[m_cnt] = in_data;
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_cnt = 0;
                        m_np  = 0;
                    end
                end
            end
            m_p = m_np;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: data j, mode 1: data j+5000, otherwise random data.
    task automatic fill(input int mode, input bit gaps, input bit chk_drop);
        int j = 0;
        int guard = 0;
        bit v;
        while (j < W && guard < 20 * W) begin
            tick();
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            case (mode)
                0:       in_data = DW'(j);
                1:       in_data = DW'(j + 5000);
                default: in_data = DW'({$urandom, $urandom});
            endcase
            #2;
            if (chk_drop && j == 1) check("buf_valid_drop_first_word", 64'(buf_valid), 64'(0));
            if (v && in_ready) j++;
            guard++;
        end
        if (j < W) check("fill_timeout", 64'(j), 64'(W));
        // keep offering unconsumable words through PRIME and DRAIN
        if (gaps) begin
            for (int i = 0; i < B + 1; i++) begin
                tick();
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'({$urandom, $urandom});
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Watches one pass: start length, done pulse, and literal beat values.
    task automatic observe_pass(input string tag, input logic [DW-1:0] e00, input logic [DW-1:0] e01,
                                input logic [DW-1:0] e150, input logic [DW-1:0] e151,
                                input logic [DW-1:0] e63);
        int n = 0;
        int guard = 0;
        @(negedge clk);
        while (!start && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!start) begin
            check({tag, "_start_timeout"}, 64'(0), 64'(1));
            return;
        end
        while (start && n < 200) begin
            if (n == 1) begin
                check({tag, "_b0_00"}, 64'(word_at(0, 0)), 64'(e00));
                check({tag, "_b0_01"}, 64'(word_at(0, 1)), 64'(e01));
                check({tag, "_b0_150"}, 64'(word_at(15, 0)), 64'(e150));
                check({tag, "_b0_151"}, 64'(word_at(15, 1)), 64'(e151));
            end
            if (n == B) check({tag, "_b63_151"}, 64'(word_at(15, 1)), 64'(e63));
            n++;
            @(negedge clk);
        end
        check({tag, "_start_len"}, 64'(n), 64'(B + 1));
        check({tag, "_done_pulse"}, 64'(done), 64'(1));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'(0));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int guard = 0;
        @(negedge clk);
        while (!done && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic small_test();
        tick();
        s_rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'(j);
            #1;
            check("s_in_ready", 64'(s_in_ready), 64'(1));
            tick();
        end
        s_in_valid = 1'b0;
        check("s_prime_start", 64'(s_start), 64'(1));
        check("s_prime_data", 64'(s_data_out), 64'(0));
        tick();
        check("s_b0_start", 64'(s_start), 64'(1));
        check("s_b0_idx", 64'(s_beat_idx), 64'(0));
        check("s_b0_data", 64'(s_data_out), 64'(32'h06020400));
        tick();
        check("s_b1_start", 64'(s_start), 64'(1));
        check("s_b1_idx", 64'(s_beat_idx), 64'(1));
        check("s_b1_data", 64'(s_data_out), 64'(32'h07030501));
        tick();
        check("s_end_start", 64'(s_start), 64'(0));
        check("s_end_done", 64'(s_done), 64'(1));
        check("s_end_buf_valid", 64'(s_buf_valid), 64'(1));
        check("s_end_data", 64'(s_data_out), 64'(0));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int guard;

        #1;
        rst   = 1'b1;
        s_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_buf_valid", 64'(buf_valid), 64'(0));
        check("reset_start", 64'(start), 64'(0));

        // replay with an empty buffer must not start a pass
        tick();
        replay = 1'b1;
        tick();
        replay = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (start) n++;
        end
        check("empty_replay_no_start", 64'(n), 64'(0));

        // single fill at full throughput, in_data = j
        fill(0, 1'b0, 1'b0);
        observe_pass("fill1", 60'd0, 60'd1024, 60'd960, 60'd1984, 60'd2047);
        repeat (3) tick();

        // replay with a simultaneous word: the word must not be taken
        replay   = 1'b1;
        in_valid = 1'b1;
        in_data  = 60'd12345;
        tick();
        replay   = 1'b0;
        in_valid = 1'b0;
        observe_pass("replay", 60'd0, 60'd1024, 60'd960, 60'd1984, 60'd2047);
        check("replay_buf_valid", 64'(buf_valid), 64'(1));

        // random valid gaps during fill, stray words during drain
        fill(0, 1'b1, 1'b0);
        wait_done("gaps", 300);

        // reset in the middle of a replay pass
        tick();
        replay = 1'b1;
        tick();
        replay = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(start && beat_idx == BW'(30)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_drain_reached", 64'(beat_idx), 64'(30));
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_start", 64'(start), 64'(0));
        check("mid_rst_beat_idx", 64'(beat_idx), 64'(0));
        check("mid_rst_buf_valid", 64'(buf_valid), 64'(0));
        check("mid_rst_data_zero", 64'(data_out == '0), 64'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // full refill with random data after the reset
        fill(2, 1'b0, 1'b0);
        wait_done("random", 300);

        // refill overwrite with j+5000
        repeat (2) tick();
        check("pre_refill_buf_valid", 64'(buf_valid), 64'(1));
        fill(1, 1'b0, 1'b1);
        observe_pass("refill", 60'd5000, 60'd6024, 60'd5960, 60'd6984, 60'd7047);

        small_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
